// File: rtl/ex_result_collector_if.sv
// rtl/ex_result_collector_if.sv - dispatch / EX writeback / commit bundle for the result collector
//
// Purpose: groups every non-clock signal of ex_result_collector. The master
// modport is the pipeline side (dispatch + EX stage); the slave modport is the
// collector itself.
//
// Signals:
//   alloc_req[1:0]   dispatch allocation request, lane 0 older
//   alloc_rd[2]      destination register of each allocating instruction
//   alloc_ready      room for two entries and no redirect pending
//   alloc_tag[2]     {phase, index} tag handed to each lane
//   results[2]       EX-stage writebacks (ex_result_t)
//   commit_valid[1:0], commit_rd[2], commit_data[2]  in-order retire port
//   redirect, redirect_pc  one-cycle fetch redirect after a squash
//   count            occupied entries, 0..BUF_SIZE
interface ex_result_collector_if #(
  parameter int BUF_SIZE_LOG = 4,
  parameter int XLEN         = 32
);
  typedef struct packed {
    logic                  is_valid;
    logic [BUF_SIZE_LOG:0] tag;
    logic [XLEN-1:0]       result;
    logic                  is_branch_established;
    logic [XLEN-1:0]       jumped_to;
  } ex_result_t;

  logic [1:0]            alloc_req;
  logic [4:0]            alloc_rd    [2];
  logic                  alloc_ready;
  logic [BUF_SIZE_LOG:0] alloc_tag   [2];
  ex_result_t            results     [2];
  logic [1:0]            commit_valid;
  logic [4:0]            commit_rd   [2];
  logic [XLEN-1:0]       commit_data [2];
  logic                  redirect;
  logic [XLEN-1:0]       redirect_pc;
  logic [BUF_SIZE_LOG:0] count;

  modport master (
    output alloc_req, alloc_rd, results,
    input  alloc_ready, alloc_tag, commit_valid, commit_rd, commit_data,
           redirect, redirect_pc, count
  );

  modport slave (
    input  alloc_req, alloc_rd, results,
    output alloc_ready, alloc_tag, commit_valid, commit_rd, commit_data,
           redirect, redirect_pc, count
  );
endinterface

// File: rtl/ex_result_collector.sv
// rtl/ex_result_collector.sv - in-order completion buffer collecting EX results and retiring in program order
//
// Purpose: dispatch allocates tagged entries (up to two per cycle), the EX
// stage writes results back by tag (up to two per cycle, out of order), and
// completed entries retire from the head in order, up to two per cycle. An
// established branch squashes every younger entry and raises a registered
// one-cycle redirect carrying the branch target.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; discards all contents
//   bus    ex_result_collector_if.slave (alloc, results, commit, redirect, count)
module ex_result_collector #(
  parameter int BUF_SIZE_LOG = 4,
  parameter int XLEN         = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ex_result_collector_if.slave  bus
);
  localparam int BUF_SIZE = 2 ** BUF_SIZE_LOG;
  localparam int PW       = BUF_SIZE_LOG + 1;

  typedef logic [PW-1:0]           ptr_t;
  typedef logic [BUF_SIZE_LOG-1:0] idx_t;

  // Pointers carry a phase bit so full (phases differ) and empty (equal) are distinct.
  ptr_t                head;
  ptr_t                tail;
  logic [BUF_SIZE-1:0] ent_valid;
  logic [BUF_SIZE-1:0] ent_done;
  logic [BUF_SIZE-1:0] ent_phase;
  logic [4:0]          ent_rd   [BUF_SIZE];
  logic [XLEN-1:0]     ent_data [BUF_SIZE];
  logic                redirect_q;
  logic [XLEN-1:0]     redirect_pc_q;

  ptr_t       count;
  logic       alloc_ready;
  ptr_t       alloc_tag1;
  logic [1:0] alloc_fire;

  assign count       = tail - head;
  assign alloc_ready = (count <= ptr_t'(BUF_SIZE - 2)) && !redirect_q;
  // Lane 1 packs into lane 0's slot when lane 0 is idle.
  assign alloc_tag1  = bus.alloc_req[0] ? tail + ptr_t'(1) : tail;
  assign alloc_fire  = bus.alloc_req & {2{alloc_ready}};

  // Writeback decode: a result is stale unless its entry is live in the same phase.
  idx_t       wb_idx [2];
  ptr_t       wb_age [2];
  logic [1:0] hit;
  logic [1:0] brn;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      wb_idx[i] = bus.results[i].tag[BUF_SIZE_LOG-1:0];
      wb_age[i] = bus.results[i].tag - head;
      hit[i]    = bus.results[i].is_valid && ent_valid[wb_idx[i]] &&
                  (ent_phase[wb_idx[i]] == bus.results[i].tag[BUF_SIZE_LOG]);
      brn[i]    = hit[i] && bus.results[i].is_branch_established;
    end
  end

  // When both lanes squash, the older branch (smaller distance from head) wins.
  logic            squash;
  logic            win_lane;
  ptr_t            win_tag;
  ptr_t            win_age;
  logic [XLEN-1:0] win_pc;

  always_comb begin
    squash   = |brn;
    win_lane = 1'b0;
    if (brn[1] && (!brn[0] || (wb_age[1] < wb_age[0])))
      win_lane = 1'b1;
    win_tag = bus.results[win_lane].tag;
    win_age = wb_age[win_lane];
    win_pc  = bus.results[win_lane].jumped_to;
  end

  // A writeback landing on an entry squashed this cycle is dropped.
  logic [1:0] wb_keep;
  always_comb begin
    for (int i = 0; i < 2; i++)
      wb_keep[i] = hit[i] && !(squash && (wb_age[i] > win_age));
  end

  ptr_t                ent_age [BUF_SIZE];
  logic [BUF_SIZE-1:0] younger;
  always_comb begin
    younger = '0;
    for (int j = 0; j < BUF_SIZE; j++) begin
      ent_age[j] = {ent_phase[j], idx_t'(j)} - head;
      younger[j] = ent_valid[j] && (ent_age[j] > win_age);
    end
  end

  // Retire strictly from state, so a result written this cycle commits next cycle at the earliest.
  idx_t head_idx0;
  idx_t head_idx1;
  logic [1:0] cv;

  assign head_idx0 = head[BUF_SIZE_LOG-1:0];
  assign head_idx1 = head_idx0 + idx_t'(1);
  assign cv[0]     = ent_valid[head_idx0] && ent_done[head_idx0];
  assign cv[1]     = cv[0] && ent_valid[head_idx1] && ent_done[head_idx1];

  assign bus.alloc_ready    = alloc_ready;
  assign bus.alloc_tag[0]   = tail;
  assign bus.alloc_tag[1]   = alloc_tag1;
  assign bus.commit_valid   = cv;
  assign bus.commit_rd[0]   = cv[0] ? ent_rd[head_idx0]   : '0;
  assign bus.commit_rd[1]   = cv[1] ? ent_rd[head_idx1]   : '0;
  assign bus.commit_data[0] = cv[0] ? ent_data[head_idx0] : '0;
  assign bus.commit_data[1] = cv[1] ? ent_data[head_idx1] : '0;
  assign bus.redirect       = redirect_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.count          = count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head          <= '0;
      tail          <= '0;
      ent_valid     <= '0;
      ent_done      <= '0;
      ent_phase     <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      head <= head + ptr_t'(cv[0]) + ptr_t'(cv[1]);
      if (squash)
        tail <= win_tag + ptr_t'(1);
      else
        tail <= tail + ptr_t'(alloc_fire[0]) + ptr_t'(alloc_fire[1]);

      redirect_q    <= squash;
      redirect_pc_q <= squash ? win_pc : '0;

      if (squash) begin
        for (int j = 0; j < BUF_SIZE; j++)
          if (younger[j]) ent_valid[j] <= 1'b0;
      end
      if (cv[0]) ent_valid[head_idx0] <= 1'b0;
      if (cv[1]) ent_valid[head_idx1] <= 1'b0;

      for (int i = 0; i < 2; i++)
        if (wb_keep[i]) ent_done[wb_idx[i]] <= 1'b1;

      // Allocations in a squash cycle are discarded; dispatch is flushed by the redirect.
      if (!squash) begin
        if (alloc_fire[0]) begin
          ent_valid[tail[BUF_SIZE_LOG-1:0]] <= 1'b1;
          ent_done[tail[BUF_SIZE_LOG-1:0]]  <= 1'b0;
          ent_phase[tail[BUF_SIZE_LOG-1:0]] <= tail[BUF_SIZE_LOG];
        end
        if (alloc_fire[1]) begin
          ent_valid[alloc_tag1[BUF_SIZE_LOG-1:0]] <= 1'b1;
          ent_done[alloc_tag1[BUF_SIZE_LOG-1:0]]  <= 1'b0;
          ent_phase[alloc_tag1[BUF_SIZE_LOG-1:0]] <= alloc_tag1[BUF_SIZE_LOG];
        end
      end
    end
  end

  // Payload storage needs no reset: valid/done gate every use.
  always_ff @(posedge clk) begin
    if (!squash) begin
      if (alloc_fire[0]) ent_rd[tail[BUF_SIZE_LOG-1:0]]       <= bus.alloc_rd[0];
      if (alloc_fire[1]) ent_rd[alloc_tag1[BUF_SIZE_LOG-1:0]] <= bus.alloc_rd[1];
    end
    for (int i = 0; i < 2; i++)
      if (wb_keep[i]) ent_data[wb_idx[i]] <= bus.results[i].result;
  end

  a_wb_lane_collision: assert property (@(posedge clk) disable iff (!rst_n)
    !(bus.results[0].is_valid && bus.results[1].is_valid && (wb_idx[0] == wb_idx[1])));

endmodule

// File: tb/tb_ex_result_collector.sv
// tb/tb_ex_result_collector.sv - scoreboard bench for ex_result_collector
module tb_ex_result_collector;
  localparam int L    = 4;
  localparam int XLEN = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ex_result_collector_if #(.BUF_SIZE_LOG(L), .XLEN(XLEN)) bus ();

  ex_result_collector #(.BUF_SIZE_LOG(L), .XLEN(XLEN)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct packed {
    logic [4:0]  tag;
    logic [4:0]  rd;
    logic [31:0] data;
  } sb_t;

  sb_t         sb[$];
  sb_t         mon_e;
  logic [31:0] plan [32];
  logic [4:0]  m_head = '0;
  logic [4:0]  m_tail = '0;
  int          n_cmp  = 0;
  int          n_err  = 0;
  int          serial = 0;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        if (bus.commit_valid[i]) begin
          if (sb.size() == 0) begin
            check("commit_unexpected", 64'(bus.commit_rd[i]), 64'hFFFF);
          end else begin
            mon_e = sb.pop_front();
            check("commit_rd", 64'(bus.commit_rd[i]), 64'(mon_e.rd));
            check("commit_data", 64'(bus.commit_data[i]), 64'(mon_e.data));
            m_head = m_head + 5'd1;
          end
        end else begin
          check("commit_data_idle", 64'(bus.commit_data[i]), 64'd0);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_wb();
    bus.results[0] = '0;
    bus.results[1] = '0;
  endtask

  task automatic drive_wb(input int lane, input logic [4:0] tag, input logic [31:0] data,
                          input logic br, input logic [31:0] jt);
    bus.results[lane].is_valid              = 1'b1;
    bus.results[lane].tag                   = tag;
    bus.results[lane].result                = data;
    bus.results[lane].is_branch_established = br;
    bus.results[lane].jumped_to             = jt;
  endtask

  task automatic do_alloc(input int n, input logic [4:0] r0, input logic [4:0] r1);
    logic [4:0] cnt;
    logic [4:0] t1;
    logic       exp_ready;
    cnt       = m_tail - m_head;
    exp_ready = (cnt <= 5'd14);
    t1        = m_tail + 5'd1;
    bus.alloc_req   = (n == 2) ? 2'b11 : 2'b01;
    bus.alloc_rd[0] = r0;
    bus.alloc_rd[1] = r1;
    #1;
    check("alloc_ready", 64'(bus.alloc_ready), 64'(exp_ready));
    check("alloc_tag0", 64'(bus.alloc_tag[0]), 64'(m_tail));
    if (n == 2) check("alloc_tag1", 64'(bus.alloc_tag[1]), 64'(t1));
    tick();
    bus.alloc_req = 2'b00;
    if (exp_ready) begin
      plan[m_tail] = 32'hD000_0000 + 32'(serial);
      serial++;
      sb.push_back('{tag: m_tail, rd: r0, data: plan[m_tail]});
      m_tail = m_tail + 5'd1;
      if (n == 2) begin
        plan[m_tail] = 32'hD000_0000 + 32'(serial);
        serial++;
        sb.push_back('{tag: m_tail, rd: r1, data: plan[m_tail]});
        m_tail = m_tail + 5'd1;
      end
    end
  endtask

  task automatic wb_plain(input int lane, input logic [4:0] tag);
    drive_wb(lane, tag, plan[tag], 1'b0, 32'd0);
  endtask

  task automatic sb_squash(input logic [4:0] btag);
    logic [4:0] bage;
    logic [4:0] eage;
    bage = btag - m_head;
    while (sb.size() > 0) begin
      eage = sb[$].tag - m_head;
      if (eage > bage) void'(sb.pop_back());
      else break;
    end
    m_tail = btag + 5'd1;
  endtask

  task automatic wait_drain(input int max_cycles);
    for (int k = 0; k < max_cycles && bus.count != 0; k++) tick();
    check("drain_count", 64'(bus.count), 64'd0);
    check("drain_model", 64'(m_head), 64'(m_tail));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    bus.alloc_req   = 2'b00;
    bus.alloc_rd[0] = '0;
    bus.alloc_rd[1] = '0;
    clear_wb();
    for (int i = 0; i < 32; i++) plan[i] = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_count", 64'(bus.count), 64'd0);
    check("rst_alloc_ready", 64'(bus.alloc_ready), 64'd1);
    check("rst_redirect", 64'(bus.redirect), 64'd0);
    check("rst_redirect_pc", 64'(bus.redirect_pc), 64'd0);
    check("rst_commit_valid", 64'(bus.commit_valid), 64'd0);
    rst_n = 1'b1;
    tick();

    // Out-of-order writeback, paired in-order retire.
    do_alloc(2, 5'd5, 5'd6);
    wb_plain(0, 5'd1);
    tick();
    clear_wb();
    check("ooo_wait", 64'(bus.commit_valid), 64'd0);
    wb_plain(0, 5'd0);
    tick();
    clear_wb();
    check("ooo_pair_valid", 64'(bus.commit_valid), 64'd3);
    check("ooo_pair_rd0", 64'(bus.commit_rd[0]), 64'd5);
    check("ooo_pair_rd1", 64'(bus.commit_rd[1]), 64'd6);
    tick();
    check("ooo_empty", 64'(bus.count), 64'd0);

    // Fill up to the allocation limit, wrapping the tail into phase 1.
    for (int k = 0; k < 7; k++) do_alloc(2, 5'(k), 5'(k + 8));
    do_alloc(1, 5'd20, 5'd0);
    check("fill_count", 64'(bus.count), 64'd15);
    check("fill_ready", 64'(bus.alloc_ready), 64'd0);
    check("fill_tag_wrap", 64'(bus.alloc_tag[0]), 64'h11);
    do_alloc(2, 5'd21, 5'd22);
    check("fill_ignored", 64'(bus.count), 64'd15);
    wb_plain(0, 5'd2);
    wb_plain(1, 5'd3);
    tick();
    clear_wb();
    tick();
    check("fill_after_commit", 64'(bus.count), 64'd13);
    check("fill_ready_again", 64'(bus.alloc_ready), 64'd1);

    // Stale result: index 3 reused as tag 5'h13, old tag 5'h03 must be dropped.
    wb_plain(0, 5'd4);
    wb_plain(1, 5'd5);
    tick();
    clear_wb();
    tick();
    do_alloc(2, 5'd23, 5'd24);
    do_alloc(2, 5'd25, 5'd26);
    drive_wb(0, 5'h03, 32'hBAD0_0003, 1'b0, 32'd0);
    tick();
    clear_wb();
    for (int t = 6; t <= 18; t += 2) begin
      wb_plain(0, 5'(t));
      if (t + 1 <= 18) wb_plain(1, 5'(t + 1));
      tick();
      clear_wb();
    end
    repeat (3) tick();
    check("stale_blocked_count", 64'(bus.count), 64'd2);
    check("stale_blocked_cv", 64'(bus.commit_valid), 64'd0);
    wb_plain(0, 5'h13);
    wb_plain(1, 5'h14);
    tick();
    clear_wb();
    wait_drain(20);

    // Asynchronous reset in the middle of traffic.
    for (int k = 0; k < 4; k++) do_alloc(2, 5'(k + 1), 5'(k + 10));
    wb_plain(0, 5'h15);
    tick();
    clear_wb();
    check("pre_reset_cv", 64'(bus.commit_valid[0]), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_count", 64'(bus.count), 64'd0);
    check("midrst_cv", 64'(bus.commit_valid), 64'd0);
    check("midrst_redirect", 64'(bus.redirect), 64'd0);
    check("midrst_ready", 64'(bus.alloc_ready), 64'd1);
    sb.delete();
    m_head = '0;
    m_tail = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // Single branch squash with a same-cycle writeback to a squashed entry and a discarded alloc.
    for (int k = 0; k < 4; k++) do_alloc(2, 5'(k + 2), 5'(k + 12));
    drive_wb(0, 5'd2, plan[2], 1'b1, 32'h100);
    drive_wb(1, 5'd5, 32'hBAD0_0005, 1'b0, 32'd0);
    bus.alloc_req   = 2'b11;
    bus.alloc_rd[0] = 5'd9;
    bus.alloc_rd[1] = 5'd9;
    #1;
    check("sq_alloc_ready_pre", 64'(bus.alloc_ready), 64'd1);
    tick();
    clear_wb();
    bus.alloc_req = 2'b00;
    sb_squash(5'd2);
    check("sq_count", 64'(bus.count), 64'd3);
    check("sq_redirect", 64'(bus.redirect), 64'd1);
    check("sq_redirect_pc", 64'(bus.redirect_pc), 64'h100);
    check("sq_ready_blocked", 64'(bus.alloc_ready), 64'd0);
    tick();
    check("sq_redirect_pulse", 64'(bus.redirect), 64'd0);
    check("sq_redirect_pc_clr", 64'(bus.redirect_pc), 64'd0);
    check("sq_count_hold", 64'(bus.count), 64'd3);
    wb_plain(0, 5'd0);
    wb_plain(1, 5'd1);
    tick();
    clear_wb();
    wait_drain(10);

    // Both lanes branch: the older one (tag 4) wins.
    for (int k = 0; k < 3; k++) do_alloc(2, 5'(k + 17), 5'(k + 27));
    drive_wb(0, 5'd6, plan[6], 1'b1, 32'h600);
    drive_wb(1, 5'd4, plan[4], 1'b1, 32'h400);
    tick();
    clear_wb();
    sb_squash(5'd4);
    check("dbl_count", 64'(bus.count), 64'd2);
    check("dbl_tail", 64'(bus.alloc_tag[0]), 64'd5);
    check("dbl_redirect_pc", 64'(bus.redirect_pc), 64'h400);
    tick();
    wb_plain(0, 5'd3);
    tick();
    clear_wb();
    wait_drain(10);
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ex_result_collector.md
Name: ex_result_collector

Overview:
Receiving end of the EX-stage result interface. Each cycle it accepts up to two ex_result_t writebacks, keyed by tag, into an in-order completion buffer that dispatch allocates. It retires completed entries in program order, up to two per cycle, to the register file. On an established branch it squashes all younger entries and issues a one-cycle fetch redirect.

Parameters:
BUF_SIZE_LOG, 4, log2 of entry count; BUF_SIZE = 2**BUF_SIZE_LOG entries
XLEN, 32, data and PC width

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
alloc_req[2]  input  1 each  dispatch allocation request; lane 0 is older
alloc_rd[2]  input  5 each  destination register of the allocated instruction
alloc_ready  output  1  at least 2 entries free and no redirect pending
alloc_tag[2]  output  BUF_SIZE_LOG+1 each  tag assigned to lane i, as {phase, index}
results[2]  input  ex_result_t each  EX-stage writebacks
commit_valid[2]  output  1 each  retire strobe; lane 0 is older
commit_rd[2]  output  5 each  retiring destination register
commit_data[2]  output  XLEN each  retiring value
redirect  output  1  registered one-cycle pulse: flush fetch/dispatch
redirect_pc  output  XLEN  jumped_to of the squashing branch; 0 when redirect=0
count  output  BUF_SIZE_LOG+1  occupied entries, 0..BUF_SIZE

Behaviour:
- State: head and tail pointers, each BUF_SIZE_LOG+1 bits; the MSB is the phase. Per entry: valid, done, phase, rd, data.
- Reset (async, rst_n=0):
  - head=tail=0; all valid/done cleared.
  - redirect=0, redirect_pc=0, commit_valid=0, count=0, alloc_ready=1.
  - Reset mid-operation discards all contents with no commit.
- Allocation:
  - alloc_tag[0]=tail; alloc_tag[1]=tail+1, or tail if alloc_req[0]=0 (packed).
  - When alloc_req&alloc_ready, the entry gets valid=1, done=0, phase=tag MSB, rd=alloc_rd; tail advances by the number of requests.
  - alloc_ready = (BUF_SIZE-count >= 2) & ~redirect.
  - A request with alloc_ready=0 is ignored; dispatch holds it.
- Writeback, per lane i with results[i].is_valid:
  - index = tag[BUF_SIZE_LOG-1:0].
  - Accepted only if entry.valid and entry.phase == tag MSB. Otherwise the result is stale and silently dropped.
  - On accept: done<=1, data<=results[i].result.
  - Both lanes to distinct entries in one cycle are both accepted. Both lanes to the same entry is illegal (assertion).
- Squash (results[i] accepted with is_branch_established=1):
  - Every entry younger than the branch has valid cleared; tail<=branch tag+1. The branch entry itself completes normally.
  - If both lanes squash, the older one (smaller (tag-head) mod 2*BUF_SIZE) wins.
  - Next cycle: redirect=1, redirect_pc=winner's jumped_to.
  - Allocations in the squash cycle are discarded.
  - A writeback to an entry squashed in the same cycle is dropped (squash wins).
- Commit (combinational from state, advances at clock edge):
  - commit_valid[0] = head entry valid & done.
  - commit_valid[1] = commit_valid[0] & (head+1) entry valid & done.
  - Retired entries clear valid; head advances 0/1/2.
  - commit_rd/commit_data are 0 when the corresponding commit_valid=0.
  - An entry written back this cycle commits no earlier than next cycle (latency ≥1 from writeback).
- Pointer arithmetic is modulo 2*BUF_SIZE. Full: count==BUF_SIZE (head/tail index equal, phases differ). Empty: head==tail.
- Allocate, writeback, commit and squash may all occur in one cycle. count_next = count + allocs − commits, or, on squash, (branch tag+1 − head_next) mod 2*BUF_SIZE.

Test Plan:
- Reset, alloc 2 (rd 5, 6), writeback tags 1 then 0 out of order -> commit waits; one cycle after tag 0's writeback both commit in the same cycle, rd=5 then 6.
- Fill 16 entries -> alloc_ready=0 at count=15; commit 2 -> alloc_ready=1; tags wrap to phase 1 (alloc_tag=5'h10).
- Stale result: entry 3 (tag 5'h03) retires, then is reallocated as tag 5'h13; writeback with tag 5'h03 -> dropped, entry not done.
- Branch tag 2 established, jumped_to=32'h100, with entries 3..7 live -> count=3, next cycle redirect=1, redirect_pc=32'h100; a lane-1 writeback to tag 5 in the same cycle is dropped.
- Both lanes branch (tags 6 and 4) -> tail=5, redirect_pc=tag 4's jumped_to.
- Assert rst_n low mid-stream with 8 entries live -> count=0, no commit_valid, redirect=0 immediately.
